// File: rtl/bcd_display_scan.sv
// Six-digit multiplexed seven-segment scanner. It snapshots x5..x0 once per scan frame
// and drives one digit every DIV cycles, with BCD decode and optional leading-zero blanking.
module bcd_display_scan #(
    parameter int DIV           = 4,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       set,
    input  logic [3:0] x5,
    input  logic [3:0] x4,
    input  logic [3:0] x3,
    input  logic [3:0] x2,
    input  logic [3:0] x1,
    input  logic [3:0] x0,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       frame
);
    localparam logic [15:0] PCNT_MAX = 16'(DIV - 1);

    logic [15:0] pcnt_q, pcnt_d;
    logic [2:0]  dsel_q, dsel_d;
    logic [23:0] snap_q, snap_d;
    logic [5:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        frame_q, frame_d;
    logic        tick_s;
    logic [3:0]  digit_s;
    logic        lead_zero_s;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] segs;
        case (code)
            4'd0:    segs = 7'h7E;
            4'd1:    segs = 7'h30;
            4'd2:    segs = 7'h6D;
            4'd3:    segs = 7'h79;
            4'd4:    segs = 7'h33;
            4'd5:    segs = 7'h5B;
            4'd6:    segs = 7'h5F;
            4'd7:    segs = 7'h70;
            4'd8:    segs = 7'h7F;
            4'd9:    segs = 7'h7B;
            default: segs = 7'h01;
        endcase
        return segs;
    endfunction

    assign tick_s = (pcnt_q == PCNT_MAX);

    // Selected digit value, and whether it and every more significant digit are zero.
    always_comb begin
        digit_s     = 4'd0;
        lead_zero_s = 1'b0;
        case (dsel_q)
            3'd5: begin
                digit_s     = snap_q[23:20];
                lead_zero_s = (snap_q[23:20] == 4'd0);
            end
            3'd4: begin
                digit_s     = snap_q[19:16];
                lead_zero_s = (snap_q[23:16] == 8'd0);
            end
            3'd3: begin
                digit_s     = snap_q[15:12];
                lead_zero_s = (snap_q[23:12] == 12'd0);
            end
            3'd2: begin
                digit_s     = snap_q[11:8];
                lead_zero_s = (snap_q[23:8] == 16'd0);
            end
            3'd1: begin
                digit_s     = snap_q[7:4];
                lead_zero_s = (snap_q[23:4] == 20'd0);
            end
            3'd0: begin
                digit_s     = snap_q[3:0];
                lead_zero_s = 1'b0;
            end
            default: begin
                digit_s     = 4'd0;
                lead_zero_s = 1'b0;
            end
        endcase
    end

    // Prescaler, digit rotation, frame snapshot and next output values.
    always_comb begin
        pcnt_d  = pcnt_q;
        dsel_d  = dsel_q;
        snap_d  = snap_q;
        frame_d = 1'b0;
        an_d    = 6'b000001 << dsel_q;
        if (BLANK_LEADING && lead_zero_s) begin
            seg_d = 7'h00;
        end else begin
            seg_d = seg_decode(digit_s);
        end
        if (dsel_q > 3'd5) begin
            // Unreachable select value: restart the scan at the top digit.
            pcnt_d = 16'd0;
            dsel_d = 3'd5;
        end else if (tick_s) begin
            pcnt_d = 16'd0;
            if (dsel_q == 3'd0) begin
                dsel_d  = 3'd5;
                snap_d  = {x5, x4, x3, x2, x1, x0};
                frame_d = 1'b1;
            end else begin
                dsel_d = dsel_q - 3'd1;
            end
        end else begin
            pcnt_d = pcnt_q + 16'd1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (set) begin
            pcnt_q  <= 16'd0;
            dsel_q  <= 3'd5;
            snap_q  <= {x5, x4, x3, x2, x1, x0};
            an_q    <= 6'd0;
            seg_q   <= 7'd0;
            frame_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            dsel_q  <= dsel_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench: three scanner instances (DIV=4 blanking, DIV=4 no blanking, DIV=1)
// compared every cycle against a frame-position reference model.
module tb_bcd_display_scan;
    logic       clk;
    logic       set;
    logic [3:0] xin [6];
    logic [5:0] an_a, an_b, an_c;
    logic [6:0] seg_a, seg_b, seg_c;
    logic       frame_a, frame_b, frame_c;
    logic [5:0] an_v  [3];
    logic [6:0] seg_v [3];
    logic       fr_v  [3];

    int n_checks = 0;
    int n_fail   = 0;

    int          div_m  [3];
    bit          bl_m   [3];
    int          n_m    [3];
    logic [23:0] snap_m [3];
    logic [5:0]  exp_an  [3];
    logic [6:0]  exp_seg [3];
    logic        exp_fr  [3];
    logic [6:0]  seg_tab [16];

    bcd_display_scan #(.DIV(4), .BLANK_LEADING(1'b1)) dut_a (
        .clk(clk), .set(set), .x5(xin[5]), .x4(xin[4]), .x3(xin[3]), .x2(xin[2]),
        .x1(xin[1]), .x0(xin[0]), .an(an_a), .seg(seg_a), .frame(frame_a));
    bcd_display_scan #(.DIV(4), .BLANK_LEADING(1'b0)) dut_b (
        .clk(clk), .set(set), .x5(xin[5]), .x4(xin[4]), .x3(xin[3]), .x2(xin[2]),
        .x1(xin[1]), .x0(xin[0]), .an(an_b), .seg(seg_b), .frame(frame_b));
    bcd_display_scan #(.DIV(1), .BLANK_LEADING(1'b1)) dut_c (
        .clk(clk), .set(set), .x5(xin[5]), .x4(xin[4]), .x3(xin[3]), .x2(xin[2]),
        .x1(xin[1]), .x0(xin[0]), .an(an_c), .seg(seg_c), .frame(frame_c));

    assign an_v[0] = an_a;  assign seg_v[0] = seg_a;  assign fr_v[0] = frame_a;
    assign an_v[1] = an_b;  assign seg_v[1] = seg_b;  assign fr_v[1] = frame_b;
    assign an_v[2] = an_c;  assign seg_v[2] = seg_c;  assign fr_v[2] = frame_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] cur_in();
        return {xin[5], xin[4], xin[3], xin[2], xin[1], xin[0]};
    endfunction

    task automatic set_in(input logic [23:0] v);
        for (int i = 0; i < 6; i++) xin[i] = v[4*i +: 4];
    endtask

    // Expected segments for digit i of snapshot s: blanked if it and all higher digits are zero.
    function automatic logic [6:0] ref_seg(input logic [23:0] s, input int i, input bit bl);
        bit lead;
        lead = bl && (i >= 1);
        for (int k = i; k <= 5; k++) begin
            if (s[4*k +: 4] != 4'd0) lead = 1'b0;
        end
        if (lead) return 7'h00;
        return seg_tab[s[4*i +: 4]];
    endfunction

    // One clock edge; the model places edge n of a frame at position (n-1) mod 6*DIV.
    task automatic clk_edge();
        logic [23:0] in_s;
        logic        set_s;
        int          p;
        int          i;
        in_s  = cur_in();
        set_s = set;
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            if (set_s) begin
                n_m[j]     = 0;
                snap_m[j]  = in_s;
                exp_an[j]  = 6'd0;
                exp_seg[j] = 7'd0;
                exp_fr[j]  = 1'b0;
            end else begin
                n_m[j]     = n_m[j] + 1;
                p          = (n_m[j] - 1) % (6 * div_m[j]);
                i          = 5 - p / div_m[j];
                exp_an[j]  = 6'(1 << i);
                exp_seg[j] = ref_seg(snap_m[j], i, bl_m[j]);
                exp_fr[j]  = ((n_m[j] % (6 * div_m[j])) == 0);
                if (exp_fr[j]) snap_m[j] = in_s;
            end
        end
    endtask

    task automatic test_reset();
        set = 1'b1;
        set_in(24'h595959);
        for (int c = 0; c < 2; c++) begin
            clk_edge();
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if (an_v[j] !== 6'd0 || seg_v[j] !== 7'd0 || fr_v[j] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset dut%0d an=%b seg=%h frame=%b, expected all zero",
                             j, an_v[j], seg_v[j], fr_v[j]);
                end
            end
        end
    endtask

    task automatic test_basic();
        set = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            clk_edge();
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if (an_v[j] !== exp_an[j] || seg_v[j] !== exp_seg[j] || fr_v[j] !== exp_fr[j]) begin
                    n_fail++;
                    $display("FAIL basic dut%0d edge%0d an=%b seg=%h frame=%b expected %b %h %b",
                             j, n, an_v[j], seg_v[j], fr_v[j], exp_an[j], exp_seg[j], exp_fr[j]);
                end
            end
            n_checks++;
            if (frame_a !== (n == 24)) begin
                n_fail++;
                $display("FAIL basic_frame edge%0d frame=%b expected %b", n, frame_a, (n == 24));
            end
            if (n == 1 || n == 5) begin
                n_checks++;
                if (an_a !== ((n == 1) ? 6'b100000 : 6'b010000) || seg_a !== ((n == 1) ? 7'h5B : 7'h7B)) begin
                    n_fail++;
                    $display("FAIL basic_digit edge%0d an=%b seg=%h", n, an_a, seg_a);
                end
            end
        end
    endtask

    task automatic test_blank();
        logic [23:0] pats [2];
        pats[0] = 24'h000107;
        pats[1] = 24'h000000;
        for (int t = 0; t < 2; t++) begin
            set = 1'b1;
            set_in(pats[t]);
            clk_edge();
            set = 1'b0;
            for (int n = 1; n <= 25; n++) begin
                clk_edge();
                for (int j = 0; j < 3; j++) begin
                    n_checks++;
                    if (an_v[j] !== exp_an[j] || seg_v[j] !== exp_seg[j] || fr_v[j] !== exp_fr[j]) begin
                        n_fail++;
                        $display("FAIL blank dut%0d edge%0d an=%b seg=%h frame=%b expected %b %h %b",
                                 j, n, an_v[j], seg_v[j], fr_v[j], exp_an[j], exp_seg[j], exp_fr[j]);
                    end
                end
                if (n == 1 || n == 13 || n == 21) begin
                    n_checks++;
                    if (seg_a !== ((n == 13 && t == 0) ? 7'h30 : (n == 21 ? ((t == 0) ? 7'h70 : 7'h7E) : 7'h00))
                        || seg_b !== ((n == 13 && t == 0) ? 7'h30 : (n == 21 && t == 0) ? 7'h70 : 7'h7E)) begin
                        n_fail++;
                        $display("FAIL blank_digit pat%0d edge%0d seg_a=%h seg_b=%h", t, n, seg_a, seg_b);
                    end
                end
            end
        end
    endtask

    task automatic test_coherence();
        int  found;
        bit  seen_frame;
        set = 1'b1;
        set_in(24'h595959);
        clk_edge();
        set   = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            clk_edge();
            if (an_a === 6'b001000) found = 1;
        end
        n_checks++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL coherence_wait an=%b never reached 001000", an_a);
        end
        set_in(24'h000001);
        seen_frame = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            clk_edge();
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if (an_v[j] !== exp_an[j] || seg_v[j] !== exp_seg[j] || fr_v[j] !== exp_fr[j]) begin
                    n_fail++;
                    $display("FAIL coherence dut%0d edge%0d an=%b seg=%h frame=%b expected %b %h %b",
                             j, n, an_v[j], seg_v[j], fr_v[j], exp_an[j], exp_seg[j], exp_fr[j]);
                end
            end
            n_checks++;
            if (!seen_frame && seg_a !== 7'h5B && seg_a !== 7'h7B) begin
                n_fail++;
                $display("FAIL coherence_old edge%0d seg=%h expected 5B or 7B", n, seg_a);
            end else if (seen_frame && an_a === 6'b100000 && seg_a !== 7'h00) begin
                n_fail++;
                $display("FAIL coherence_new edge%0d seg=%h expected 00", n, seg_a);
            end
            if (frame_a === 1'b1) seen_frame = 1'b1;
        end
    endtask

    task automatic test_invalid();
        set = 1'b1;
        set_in(24'h00A000);
        clk_edge();
        set = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            clk_edge();
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if (an_v[j] !== exp_an[j] || seg_v[j] !== exp_seg[j] || fr_v[j] !== exp_fr[j]) begin
                    n_fail++;
                    $display("FAIL invalid dut%0d edge%0d an=%b seg=%h frame=%b expected %b %h %b",
                             j, n, an_v[j], seg_v[j], fr_v[j], exp_an[j], exp_seg[j], exp_fr[j]);
                end
            end
            if (n == 9 || n == 13) begin
                n_checks++;
                if (seg_a !== ((n == 9) ? 7'h01 : 7'h7E)) begin
                    n_fail++;
                    $display("FAIL invalid_digit edge%0d seg=%h", n, seg_a);
                end
            end
        end
    endtask

    task automatic test_midreset();
        int found;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            clk_edge();
            if (an_a === 6'b000100) found = 1;
        end
        n_checks++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL midreset_wait an=%b never reached 000100", an_a);
        end
        set = 1'b1;
        set_in(24'h812345);
        clk_edge();
        n_checks++;
        if (an_a !== 6'd0 || seg_a !== 7'd0 || frame_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear an=%b seg=%h frame=%b expected zeros", an_a, seg_a, frame_a);
        end
        set = 1'b0;
        set_in(24'h000000);
        clk_edge();
        n_checks++;
        if (an_a !== 6'b100000 || seg_a !== 7'h7F || an_b !== 6'b100000 || seg_b !== 7'h7F) begin
            n_fail++;
            $display("FAIL midreset_restart an=%b seg=%h expected 100000 7F", an_a, seg_a);
        end
        for (int n = 2; n <= 26; n++) begin
            clk_edge();
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if (an_v[j] !== exp_an[j] || seg_v[j] !== exp_seg[j] || fr_v[j] !== exp_fr[j]) begin
                    n_fail++;
                    $display("FAIL midreset dut%0d edge%0d an=%b seg=%h frame=%b expected %b %h %b",
                             j, n, an_v[j], seg_v[j], fr_v[j], exp_an[j], exp_seg[j], exp_fr[j]);
                end
            end
        end
    endtask

    task automatic test_div1();
        logic prev_fr;
        int   frames;
        set = 1'b1;
        set_in(24'h123456);
        clk_edge();
        set     = 1'b0;
        prev_fr = 1'b0;
        frames  = 0;
        for (int n = 1; n <= 18; n++) begin
            clk_edge();
            n_checks++;
            if (an_c !== exp_an[2] || seg_c !== exp_seg[2] || frame_c !== exp_fr[2]) begin
                n_fail++;
                $display("FAIL div1 edge%0d an=%b seg=%h frame=%b expected %b %h %b",
                         n, an_c, seg_c, frame_c, exp_an[2], exp_seg[2], exp_fr[2]);
            end
            n_checks++;
            if (an_c !== 6'(1 << (5 - (n - 1) % 6)) || (prev_fr === 1'b1 && an_c !== 6'b100000)) begin
                n_fail++;
                $display("FAIL div1_rotate edge%0d an=%b", n, an_c);
            end
            if (frame_c === 1'b1) frames++;
            prev_fr = frame_c;
        end
        n_checks++;
        if (frames != 3) begin
            n_fail++;
            $display("FAIL div1_frames count=%0d expected 3", frames);
        end
    endtask

    task automatic test_random();
        logic [23:0] v;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int d = 0; d < 6; d++)
                    v[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                set_in(v);
            end
            set = ($urandom_range(0, 39) == 0);
            clk_edge();
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if (an_v[j] !== exp_an[j] || seg_v[j] !== exp_seg[j] || fr_v[j] !== exp_fr[j]) begin
                    n_fail++;
                    $display("FAIL random dut%0d step%0d an=%b seg=%h frame=%b expected %b %h %b",
                             j, n, an_v[j], seg_v[j], fr_v[j], exp_an[j], exp_seg[j], exp_fr[j]);
                end
            end
        end
        set = 1'b0;
    endtask

    initial begin
        seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                    7'h7F, 7'h7B, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01};
        div_m = '{4, 4, 1};
        bl_m  = '{1'b1, 1'b0, 1'b1};
        for (int j = 0; j < 3; j++) begin
            n_m[j]    = 0;
            snap_m[j] = 24'd0;
        end
        set = 1'b1;
        set_in(24'h000000);
        test_reset();
        test_basic();
        test_blank();
        test_coherence();
        test_invalid();
        test_midreset();
        test_div1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Multiplexed seven-segment scanner for the six-digit BCD countdown timer (`x5`..`x0`, HH:MM:SS). It captures one coherent snapshot of all six digits per scan frame and drives one digit at a time. Digit dwell is set by a prescaler. The block decodes BCD to segments, blanks leading zeros and shows a dash for non-BCD codes. It sits between the timer and the board's common-bus LED display.

## Interface
- `DIV`, 4: clock cycles each digit is driven; legal range 1..65535.
- `BLANK_LEADING`, 1: 1 enables leading-zero blanking; 0 shows every digit.
- `clk`  in  1  rising-edge clock; the only clock.
- `set`  in  1  reset, synchronous, active-high; overrides all other activity.
- `x5`..`x0`  in  4 each  BCD digits, `x5` most significant (hours tens).
- `an`  out  6  one-hot active-high digit enable; bit i drives digit `xi`.
- `seg`  out  7  active-high segments; `seg[6]`=a … `seg[0]`=g.
- `frame`  out  1  one-cycle pulse when a new snapshot is taken.

## Operation
- **State**
  - Prescaler `pcnt`, 0..DIV-1.
  - Digit select `dsel`, 0..5.
  - 24-bit snapshot `snap`.
- **Registered outputs.** `an`, `seg` and `frame` are all registered.
- **Reset** (any edge with `set`=1):
  - Internal state: `pcnt`<=0, `dsel`<=5, `snap`<={x5..x0}.
  - Outputs: `an`<=0, `seg`<=0, `frame`<=0.
- **Prescaler.** `tick` = (`pcnt`==DIV-1). On tick `pcnt` wraps to 0; otherwise it increments.
- **Scan order.** On tick `dsel` steps 5→4→3→2→1→0→5.
  - The tick that moves `dsel` from 0 to 5 also loads `snap`<={x5..x0} and registers `frame`<=1.
  - `frame` is 0 on every other edge.
- **Digit outputs.** Every non-reset edge:
  - `an`<=onehot(`dsel`).
  - `seg`<=decode(`snap` digit `dsel`), using pre-edge values of `dsel` and `snap`.
- **Decode** (hex):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33
  - 5=5B, 6=5F, 7=70, 8=7F, 9=7B
  - Codes 10..15 decode to 01 (segment g only, a dash).
- **Blanking.** With BLANK_LEADING=1, digit i≥1 is blanked when snap digits i..5 are all zero.
  - Blanked means `seg`=00; `an` still asserts.
  - Digit 0 is never blanked.
  - An invalid code is nonzero, so it stops blanking for all lower digits.
- **Input isolation.** Input changes between snapshots have no effect on `an`, `seg` or `frame`.

## Timing
- **First digit.** First edge with `set`=0 gives `an`=100000 and `seg`=decode(`x5` sampled at reset).
- **Dwell and frame length.** Each digit is held exactly DIV consecutive cycles; a frame is 6·DIV cycles.
- **DIV=1.** Tick every cycle; `an` rotates every cycle; `frame` pulses every 6th cycle.
- **Snapshot latency.** The first digit from a new snapshot appears on the edge after `frame`=1, so `frame` leads the new `an`=100000 by one cycle.
- **`frame` timing.** No `frame` pulse on reset. The first pulse comes 6·DIV edges after reset release.
- **Reset mid-frame.** The next edge gives `an`=0, `seg`=0, `frame`=0 and `dsel`=5; the scan restarts from `x5` as after power-up.
- **Simultaneous events.** `set` together with a frame-end tick resolves as reset: no `frame` pulse, and `snap` is reloaded from the inputs.

## Test plan
1. **Basic scan.** DIV=4, inputs 5,9,5,9,5,9, reset 2 cycles then release.
   - `an` must step 100000,010000,…,000001, each held 4 cycles.
   - `seg` must read 5B,7B,5B,7B,5B,7B.
   - `frame`=1 exactly at cycle 24 after release.
2. **Leading-zero blanking.** Inputs 0,0,0,1,0,7 → `seg` 00,00,00,30,7E,70.
   - Inputs all zero → 00×5, then 7E on digit 0.
   - Same stimulus with BLANK_LEADING=0 → 7E on all six digits.
3. **Snapshot coherence.** Change inputs from 5,9,5,9,5,9 to 0,0,0,0,0,1 while `an`=001000.
   - `seg` must keep showing 5B/7B through the end of the current frame.
   - The new values must appear from the `an`=100000 following `frame`=1.
4. **Invalid code.** `x3`=4'hA, others 0.
   - Digits 5 and 4 blanked (00), digit 3 = 01.
   - Digits 2,1,0 = 7E, i.e. not blanked.
5. **Reset mid-frame.** Assert `set` for 1 cycle while `an`=000100.
   - Next edge must give `an`=0, `seg`=0, `frame`=0.
   - The following edge must give `an`=100000 with the inputs sampled at reset.
6. **DIV=1 wrap.** Instantiate with DIV=1.
   - `an` must rotate every cycle, 5→0 and then wrap back to 5.
   - `frame` must pulse every 6 cycles, one cycle before each `an`=100000.
